// File: rtl/fir_hls_mul_pipe_if.sv
// fir_hls_mul_pipe_if: operand/result handshake bundle for fir_hls_mul_pipe.
// Master drives operands and out_ready; slave returns in_ready and results.
interface fir_hls_mul_pipe_if #(
   parameter int DIN0_WIDTH = 16,
   parameter int DIN1_WIDTH = 10,
   parameter int DOUT_WIDTH = 26
);
   logic signed [DIN0_WIDTH-1:0] din0;
   logic signed [DIN1_WIDTH-1:0] din1;
   logic                         in_valid;
   logic                         in_ready;
   logic signed [DOUT_WIDTH-1:0] dout;
   logic                         dout_vld;
   logic                         out_ready;
   logic                         dout_sat;

   modport master (
      output din0, din1, in_valid, out_ready,
      input  in_ready, dout, dout_vld, dout_sat
   );

   modport slave (
      input  din0, din1, in_valid, out_ready,
      output in_ready, dout, dout_vld, dout_sat
   );
endinterface

// File: rtl/fir_hls_mul_pipe.sv
// fir_hls_mul_pipe: pipelined signed multiply, round/shift and narrow, global stall.
// Define FIR_HLS_MUL_PIPE_SAT_EN to saturate on narrowing instead of wrapping.
module fir_hls_mul_pipe #(
   parameter int ID         = 1,
   parameter int DIN0_WIDTH = 16,
   parameter int DIN1_WIDTH = 10,
   parameter int DOUT_WIDTH = 26,
   parameter int SHIFT      = 0,
   parameter int ROUND      = 0,
   parameter int NUM_STAGE  = 2
) (
   input logic               ap_clk,
   input logic               ap_rst,
   fir_hls_mul_pipe_if.slave bus
);
   localparam int P  = DIN0_WIDTH + DIN1_WIDTH;
   localparam int RW = P + 1;
   localparam int NP = (NUM_STAGE > 2) ? NUM_STAGE - 2 : 1;
   localparam logic [RW-1:0] RC = (ROUND != 0 && SHIFT > 0) ?
      (RW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

   logic [NUM_STAGE-1:0]         r_vld;
   logic                         w_adv;
   logic signed [P-1:0]          w_prod;
   logic signed [RW-1:0]         w_sum;
   logic signed [RW-1:0]         w_r;
   logic signed [DOUT_WIDTH-1:0] w_res;
   logic signed [DOUT_WIDTH-1:0] r_dout;
   logic                         w_sat;
   logic                         r_sat;

   assign w_adv        = bus.out_ready | ~r_vld[NUM_STAGE-1];
   assign bus.in_ready = w_adv;
   assign bus.dout     = r_dout;
   assign bus.dout_vld = r_vld[NUM_STAGE-1];
   assign bus.dout_sat = r_sat;

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         r_vld <= '0;
      end else if (w_adv) begin
         r_vld[0] <= bus.in_valid;
         for (int i = 1; i < NUM_STAGE; i++)
            r_vld[i] <= r_vld[i-1];
      end
   end

   generate
      if (NUM_STAGE == 1) begin : g_comb
         assign w_prod = P'(bus.din0) * P'(bus.din1);
      end else begin : g_reg
         logic signed [DIN0_WIDTH-1:0] r_a;
         logic signed [DIN1_WIDTH-1:0] r_b;
         logic signed [P-1:0]          w_mul;

         assign w_mul = P'(r_a) * P'(r_b);

         always_ff @(posedge ap_clk) begin
            if (w_adv) begin
               r_a <= bus.din0;
               r_b <= bus.din1;
            end
         end

         if (NUM_STAGE == 2) begin : g_s2
            assign w_prod = w_mul;
         end else begin : g_sn
            logic signed [P-1:0] r_p [NP];

            always_ff @(posedge ap_clk) begin
               if (w_adv) begin
                  r_p[0] <= w_mul;
                  for (int i = 1; i < NP; i++)
                     r_p[i] <= r_p[i-1];
               end
            end

            assign w_prod = r_p[NP-1];
         end
      end
   endgenerate

   // one extra bit so the rounding constant can never overflow
   assign w_sum = RW'(w_prod) + RC;
   assign w_r   = w_sum >>> SHIFT;

   generate
      if (DOUT_WIDTH >= RW - SHIFT) begin : g_fit
         assign w_res = DOUT_WIDTH'(w_r);
         assign w_sat = 1'b0;
      end else begin : g_nar
`ifdef FIR_HLS_MUL_PIPE_SAT_EN
         logic w_ovf;
         assign w_ovf = w_r[RW-1:DOUT_WIDTH-1] !=
                        {(RW-DOUT_WIDTH+1){w_r[RW-1]}};
         assign w_res = !w_ovf    ? DOUT_WIDTH'(w_r) :
                        w_r[RW-1] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}} :
                                    {1'b0, {(DOUT_WIDTH-1){1'b1}}};
         assign w_sat = w_ovf;
`else
         assign w_res = DOUT_WIDTH'(w_r);
         assign w_sat = 1'b0;
`endif
      end
   endgenerate

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         r_dout <= '0;
         r_sat  <= 1'b0;
      end else if (w_adv) begin
         r_dout <= w_res;
         r_sat  <= w_sat;
      end
   end
endmodule

// File: tb/tb_fir_hls_mul_pipe.sv
// tb_fir_hls_mul_pipe: directed and model-checked bench for fir_hls_mul_pipe.
// Several instances cover widths, shift/round, depth and the saturation build.
module tb_fir_hls_mul_pipe;
   logic clk = 1'b0;
   logic ap_rst;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   k, n;
   logic signed [25:0] prev;
   bit       mv4, a4, a5;
   longint   md4;
   bit [3:0] mv5;
   longint   md5 [4];

   always #5 clk = ~clk;

   fir_hls_mul_pipe_if #(16, 10, 26) b0 ();
   fir_hls_mul_pipe_if #(16, 10, 16) b1 ();
   fir_hls_mul_pipe_if #(16, 10, 26) b2 ();
   fir_hls_mul_pipe_if #(16, 10, 26) b3 ();
   fir_hls_mul_pipe_if #(16, 10, 26) b4 ();
   fir_hls_mul_pipe_if #(16, 10, 26) b5 ();

   fir_hls_mul_pipe #(.ID(0)) u0 (
      .ap_clk(clk), .ap_rst(ap_rst), .bus(b0));
   fir_hls_mul_pipe #(.ID(1), .DOUT_WIDTH(16), .SHIFT(8)) u1 (
      .ap_clk(clk), .ap_rst(ap_rst), .bus(b1));
   fir_hls_mul_pipe #(.ID(2), .SHIFT(8), .ROUND(1)) u2 (
      .ap_clk(clk), .ap_rst(ap_rst), .bus(b2));
   fir_hls_mul_pipe #(.ID(3), .SHIFT(8), .ROUND(0)) u3 (
      .ap_clk(clk), .ap_rst(ap_rst), .bus(b3));
   fir_hls_mul_pipe #(.ID(4), .NUM_STAGE(1)) u4 (
      .ap_clk(clk), .ap_rst(ap_rst), .bus(b4));
   fir_hls_mul_pipe #(.ID(5), .NUM_STAGE(4), .SHIFT(4), .ROUND(1)) u5 (
      .ap_clk(clk), .ap_rst(ap_rst), .bus(b5));

   task automatic chk(input string tag,
                      input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      ap_rst = 1'b1;
      b0.in_valid = 0; b0.out_ready = 1; b0.din0 = 0; b0.din1 = 0;
      b1.in_valid = 0; b1.out_ready = 1; b1.din0 = 0; b1.din1 = 0;
      b2.in_valid = 0; b2.out_ready = 1; b2.din0 = 0; b2.din1 = 0;
      b3.in_valid = 0; b3.out_ready = 1; b3.din0 = 0; b3.din1 = 0;
      b4.in_valid = 0; b4.out_ready = 1; b4.din0 = 0; b4.din1 = 0;
      b5.in_valid = 0; b5.out_ready = 1; b5.din0 = 0; b5.din1 = 0;
      #2;
      chk("rst_vld", b0.dout_vld, 0);
      chk("rst_dout", b0.dout, 0);
      chk("rst_sat", b0.dout_sat, 0);
      chk("rst_rdy", b0.in_ready, 1);
      step; step;
      @(negedge clk) ap_rst = 1'b0;
      step;

      // default config: most negative operands
      b0.din0 = 16'sh8000; b0.din1 = 10'sh200; b0.in_valid = 1;
      step;
      b0.in_valid = 0;
      chk("t1_vld_t1", b0.dout_vld, 0);
      step;
      chk("t1_vld_t2", b0.dout_vld, 1);
      chk("t1_dout", b0.dout, 16777216);
      chk("t1_sat", b0.dout_sat, 0);
      step;
      chk("t1_vld_t3", b0.dout_vld, 0);

      // narrow to 16 bits after >>>8
      b1.din0 = 16'sh8000; b1.din1 = 10'sh200; b1.in_valid = 1;
      step;
      b1.in_valid = 0;
      step;
      chk("t2_vld", b1.dout_vld, 1);
`ifdef FIR_HLS_MUL_PIPE_SAT_EN
      chk("t2_dout", b1.dout, 32767);
      chk("t2_sat", b1.dout_sat, 1);
`else
      chk("t2_dout", b1.dout, 0);
      chk("t2_sat", b1.dout_sat, 0);
`endif

      // rounding vs truncation
      b2.din0 = 384; b2.din1 = 1; b2.in_valid = 1;
      b3.din0 = 384; b3.din1 = 1; b3.in_valid = 1;
      step;
      b2.din0 = -384; b3.din0 = -384;
      step;
      b2.in_valid = 0; b3.in_valid = 0;
      chk("t3_rnd_pos", b2.dout, 2);
      chk("t3_trn_pos", b3.dout, 1);
      step;
      chk("t3_rnd_neg", b2.dout, -1);
      chk("t3_trn_neg", b3.dout, -2);

      // backpressure: stall cycles 4..8
      k = 0; n = 0; prev = '0;
      for (int c = 0; c < 30; c++) begin
         b0.in_valid  = (k < 10);
         b0.din0      = 16'(k + 1);
         b0.din1      = 3;
         b0.out_ready = !(c >= 4 && c <= 8);
         #1;
         chk("t4_rdy", b0.in_ready, (c >= 4 && c <= 8) ? 0 : 1);
         if (c >= 5 && c <= 8)
            chk("t4_hold", b0.dout, prev);
         if (b0.dout_vld && b0.out_ready) begin
            chk("t4_dout", b0.dout, 3 * (n + 1));
            n++;
         end
         prev = b0.dout;
         if (b0.in_valid && b0.in_ready)
            k++;
         step;
      end
      b0.in_valid = 0; b0.out_ready = 1;
      chk("t4_count", n, 10);
      chk("t4_sent", k, 10);

      // reset with two results in flight
      b0.din0 = 2; b0.din1 = 3; b0.in_valid = 1;
      step;
      b0.din0 = 4;
      step;
      b0.in_valid = 0;
      chk("t5_pre_vld", b0.dout_vld, 1);
      chk("t5_pre_dout", b0.dout, 6);
      ap_rst = 1'b1;
      #1;
      chk("t5_async_vld", b0.dout_vld, 0);
      chk("t5_async_dout", b0.dout, 0);
      step;
      @(negedge clk) ap_rst = 1'b0;
      step;
      for (int i = 0; i < 3; i++) begin
         chk("t5_no_stale", b0.dout_vld, 0);
         step;
      end
      b0.din0 = 7; b0.din1 = 5; b0.in_valid = 1;
      step;
      b0.in_valid = 0;
      chk("t5_lat_t1", b0.dout_vld, 0);
      step;
      chk("t5_lat_t2", b0.dout_vld, 1);
      chk("t5_dout", b0.dout, 35);

      // random traffic on depth 1 and depth 4
      mv4 = 0; md4 = 0; mv5 = '0;
      for (int i = 0; i < 4; i++) md5[i] = 0;
      for (int c = 0; c < 300; c++) begin
         b4.in_valid  = ($urandom_range(0, 3) != 0);
         b4.din0      = 16'($urandom);
         b4.din1      = 10'($urandom);
         b4.out_ready = 1'($urandom_range(0, 1));
         b5.in_valid  = ($urandom_range(0, 3) != 0);
         b5.din0      = 16'($urandom);
         b5.din1      = 10'($urandom);
         b5.out_ready = 1'($urandom_range(0, 1));
         #1;
         a4 = b4.out_ready | !mv4;
         a5 = b5.out_ready | !mv5[3];
         chk("t6_n1_rdy", b4.in_ready, a4);
         chk("t6_n1_vld", b4.dout_vld, mv4);
         if (mv4)
            chk("t6_n1_dout", b4.dout, md4);
         chk("t6_n4_rdy", b5.in_ready, a5);
         chk("t6_n4_vld", b5.dout_vld, mv5[3]);
         if (mv5[3])
            chk("t6_n4_dout", b5.dout, md5[3]);
         if (a4) begin
            mv4 = b4.in_valid;
            md4 = longint'(b4.din0) * longint'(b4.din1);
         end
         if (a5) begin
            for (int i = 3; i > 0; i--) begin
               mv5[i] = mv5[i-1];
               md5[i] = md5[i-1];
            end
            mv5[0] = b5.in_valid;
            md5[0] = (longint'(b5.din0) * longint'(b5.din1) + 8) >>> 4;
         end
         step;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/fir_hls_mul_pipe.md
Name: fir_hls_mul_pipe

Overview:
- Parametrised, pipelined signed multiplier that replaces the single-cycle combinational multiplier cores in the FIR datapath.
- Adds a configurable pipeline depth, valid/ready flow control with a global stall, and post-product scaling: arithmetic right shift with optional round-half-up.
- Output narrowing either wraps or, when the optional feature is compiled in, saturates.
- Sits between coefficient/sample fetch and the transposed-form accumulator chain.

Parameters:
- ID, 1, instance tag; no functional effect
- DIN0_WIDTH, 16, sample operand width (signed)
- DIN1_WIDTH, 10, coefficient operand width (signed)
- DOUT_WIDTH, 26, result width (signed)
- SHIFT, 0, arithmetic right shift applied to the full product; 0..DIN0_WIDTH+DIN1_WIDTH-1
- ROUND, 0, 0 = truncate toward -inf; 1 = round half up before the shift (ignored when SHIFT=0)
- NUM_STAGE, 2, pipeline latency in cycles; minimum 1

Ports:
- ap_clk  in  1  clock; all flops sample on the rising edge
- ap_rst  in  1  reset, asynchronous, active-high
- din0  in  DIN0_WIDTH  signed sample
- din1  in  DIN1_WIDTH  signed coefficient
- in_valid  in  1  din0/din1 qualified
- in_ready  out  1  block accepts din0/din1 this cycle
- dout  out  DOUT_WIDTH  scaled signed result
- dout_vld  out  1  dout qualified
- out_ready  in  1  downstream accepts dout this cycle
- dout_sat  out  1  dout was clamped; qualified by dout_vld

Behaviour:
- Reset: ap_rst clears all stage valid bits immediately and asynchronously. dout_vld=0, dout=0, dout_sat=0. in_ready=1 once the valid bits are clear. Data registers need not be reset, except the output register, which resets to 0.
- Reset mid-operation: all in-flight results are discarded. None appear after reset release.
- Pipeline and stall:
  - Internal signal adv = out_ready | ~dout_vld.
  - in_ready = adv, combinational.
  - When adv=1, every stage shifts forward by one. Stage 0 loads din0/din1 with valid = in_valid.
  - When adv=0, all stages and dout/dout_vld/dout_sat hold bit-exact.
  - The stall is global: no bubble collapsing.
- Latency: a transfer accepted at cycle t (in_valid & in_ready) gives dout_vld=1 at cycle t+NUM_STAGE when no stall occurs. Each stall cycle adds one cycle.
- Throughput: one result per cycle while out_ready=1.
- Arithmetic:
  - P = DIN0_WIDTH+DIN1_WIDTH. The full product is computed in P bits and never overflows.
  - r = (prod + (ROUND && SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT, evaluated in P+1 bits so that adding the rounding constant cannot overflow.
  - Narrowing to DOUT_WIDTH follows the Optional Feature rules. If DOUT_WIDTH >= P+1-SHIFT, r is sign-extended and dout_sat=0.
- Stage mapping:
  - Stage 0 registers the operands.
  - Stages 1..NUM_STAGE-2 carry the product.
  - The final stage registers the rounded, narrowed result and dout_sat.
  - NUM_STAGE=1 means a single output register fed by the combinational multiply, round and narrow path.
- Simultaneous in_valid and out_ready with a full pipeline: the output is consumed and the new input is accepted in the same cycle.
- in_valid=0 while adv=1 inserts a bubble. dout_vld drops for that slot.
- dout value while dout_vld=0 is don't-care, apart from its reset value.

Optional Feature:
- Macro: FIR_HLS_MUL_PIPE_SAT_EN.
- Defined: if r is outside [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1], dout is clamped to the nearer bound and dout_sat=1 for that result.
- Undefined: dout = the low DOUT_WIDTH bits of r (two's-complement wrap). dout_sat is tied to 0, and no comparison logic is synthesised.

Test Plan:
1. Defaults (16/10/26, SHIFT=0, NUM_STAGE=2): din0=-32768, din1=-512, single transfer at cycle t -> dout=16777216 (0x1000000), dout_vld=1 at t+2 only, dout_sat=0.
2. DOUT_WIDTH=16, SHIFT=8, same operands -> with FIR_HLS_MUL_PIPE_SAT_EN: dout=32767, dout_sat=1. Without the macro: dout=0, dout_sat=0.
3. SHIFT=8, din0=384, din1=1 -> ROUND=1: dout=2; ROUND=0: dout=1. Then din0=-384 -> ROUND=1: dout=-1; ROUND=0: dout=-2.
4. Backpressure: stream din0=1..10, din1=3, with out_ready=0 for cycles 4-8 -> in_ready=0 in exactly those cycles once dout_vld=1, and dout holds stable. Output sequence is 3,6,...,30 in order, with no loss or duplication.
5. Reset mid-stream: assert ap_rst with 2 results in flight -> dout_vld=0 asynchronously. After release, no stale result appears, and the first new input emerges after NUM_STAGE cycles.
6. NUM_STAGE=1 and NUM_STAGE=4: random operands with out_ready toggling randomly -> results bit-match the reference model at the required latency.
